// File: rtl/shift_register_universal.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register_universal
//  Description : Parametrised universal shift register with hold, shift
//                right, shift left and parallel load. Provides a registered
//                serial output, a same-direction bit counter and a one-cycle
//                word-complete strobe. Used as the serial/parallel conversion
//                stage in front of the serial link and UART datapaths.
//  Revision    : 1.0  - initial release (successor to fixed 4-bit SIPO)
// ============================================================================
module shift_register_universal #(
    parameter int WIDTH = 8,   // register width in bits, >= 1
    parameter int CNT_W = 4    // counter width, 2**CNT_W must exceed WIDTH
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             d_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] q,
    output logic             s_out,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_valid
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Direction FSM: remembers which way the previous shift went so that a
    // run of same-direction shifts can be counted into whole words.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHR  = 2'd1;
    localparam logic [1:0] ST_SHL  = 2'd2;

    // Number of shifts that make up one complete word.
    localparam logic [CNT_W-1:0] C_WORD_LEN = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State registers and next-state values
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] data_q,  data_d;
    logic             sout_q,  sout_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             wv_q,    wv_d;
    logic [1:0]       state_q, state_d;

    // ------------------------------------------------------------------------
    // Shifted data and the bit that falls off each end
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_shr_data;
    logic [WIDTH-1:0] w_shl_data;
    logic             w_shr_out;
    logic             w_shl_out;

    generate
        if (WIDTH == 1) begin : g_narrow
            // A one-bit register simply takes the serial input either way.
            assign w_shr_data = d_in;
            assign w_shl_data = d_in;
            assign w_shr_out  = data_q[0];
            assign w_shl_out  = data_q[0];
        end else begin : g_wide
            // Right shift: serial data enters at the MSB, LSB leaves.
            assign w_shr_data = {d_in, data_q[WIDTH-1:1]};
            // Left shift: serial data enters at the LSB, MSB leaves.
            assign w_shl_data = {data_q[WIDTH-2:0], d_in};
            assign w_shr_out  = data_q[0];
            assign w_shl_out  = data_q[WIDTH-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Word counting for the shift requested this cycle
    // ------------------------------------------------------------------------
    logic [1:0]       w_shift_dir;
    logic [CNT_W-1:0] w_run_len;
    logic             w_word_done;

    // Length of the current same-direction run including this shift; a new
    // direction (or coming from IDLE) restarts the run at one.
    always_comb begin
        w_shift_dir = (mode == MODE_SHR) ? ST_SHR : ST_SHL;
        if (state_q == w_shift_dir) begin
            w_run_len = cnt_q + C_CNT_ONE;
        end else begin
            w_run_len = C_CNT_ONE;
        end
        w_word_done = (w_run_len == C_WORD_LEN);
    end

    // ------------------------------------------------------------------------
    // Next-state selection: clear beats enable, enable beats mode
    // ------------------------------------------------------------------------
    // Compute the value every register takes on the next rising edge.
    always_comb begin
        data_d  = data_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        wv_d    = 1'b0;

        if (clr) begin
            data_d  = '0;
            sout_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (en) begin
            case (mode)
                MODE_HOLD: begin
                    // Everything holds; the strobe drops.
                end
                MODE_LOAD: begin
                    // A load starts a fresh word; s_out keeps its last value.
                    data_d  = p_in;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
                MODE_SHR, MODE_SHL: begin
                    if (mode == MODE_SHR) begin
                        data_d = w_shr_data;
                        sout_d = w_shr_out;
                    end else begin
                        data_d = w_shl_data;
                        sout_d = w_shl_out;
                    end
                    state_d = w_shift_dir;
                    if (w_word_done) begin
                        // Word boundary: counter wraps so the next shift in
                        // the same direction begins the next word at one.
                        cnt_d = '0;
                        wv_d  = 1'b1;
                    end else begin
                        cnt_d = w_run_len;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // All state updates on the rising edge; reset abandons any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            wv_q    <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            data_q  <= data_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            wv_q    <= wv_d;
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------------
    assign q          = data_q;
    assign s_out      = sout_q;
    assign bit_cnt    = cnt_q;
    assign word_valid = wv_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_universal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_register_universal
//  Description : Self-checking bench for shift_register_universal. Directed
//                scenarios followed by randomised traffic, all compared
//                against a behavioural model of the register.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_shift_register_universal;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             d_in = 1'b0;
    logic [WIDTH-1:0] p_in = '0;
    logic [WIDTH-1:0] q;
    logic             s_out;
    logic [CNT_W-1:0] bit_cnt;
    logic             word_valid;

    shift_register_universal #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .mode       (mode),
        .d_in       (d_in),
        .p_in       (p_in),
        .q          (q),
        .s_out      (s_out),
        .bit_cnt    (bit_cnt),
        .word_valid (word_valid)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural model: the register is a number, the counter is the length
    // of the current same-direction run (unbounded), and a word completes
    // whenever that run length is a multiple of WIDTH.
    // ------------------------------------------------------------------------
    int unsigned m_val;   // register contents as an integer
    int          m_sout;
    int          m_dir;   // 0 none, +1 right, -1 left
    int          m_run;   // consecutive shifts in m_dir since reset/clr/load
    int          m_wv;

    int total  = 0;
    int passed = 0;

    function automatic void model_reset();
        m_val = 0; m_sout = 0; m_dir = 0; m_run = 0; m_wv = 0;
    endfunction

    function automatic void model_edge(input int e, input int c, input int md,
                                       input int d, input int p);
        int dir;
        m_wv = 0;
        if (c != 0) begin
            model_reset();
        end else if (e != 0 && md == 3) begin
            m_val = p;
            m_run = 0;
            m_dir = 0;
        end else if (e != 0 && (md == 1 || md == 2)) begin
            dir = (md == 1) ? 1 : -1;
            if (dir == 1) begin
                m_sout = m_val % 2;
                m_val  = m_val / 2 + d * (1 << (WIDTH - 1));
            end else begin
                m_sout = (m_val / (1 << (WIDTH - 1))) % 2;
                m_val  = (m_val * 2 + d) % (1 << WIDTH);
            end
            if (dir != m_dir) m_run = 0;
            m_dir = dir;
            m_run = m_run + 1;
            m_wv  = (m_run % WIDTH == 0) ? 1 : 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q"},          32'(q),          32'(m_val));
        chk({tag, ".s_out"},      32'(s_out),      32'(m_sout));
        chk({tag, ".bit_cnt"},    32'(bit_cnt),    32'(m_run % WIDTH));
        chk({tag, ".word_valid"}, 32'(word_valid), 32'(m_wv));
    endtask

    // Drive one cycle's inputs (just after an edge), clock, then check.
    task automatic step(input string tag, input logic e, input logic c,
                        input logic [1:0] md, input logic d, input logic [WIDTH-1:0] p);
        en = e; clr = c; mode = md; d_in = d; p_in = p;
        @(posedge clk);
        model_edge(int'(e), int'(c), int'(md), int'(d), int'(p));
        #1;
        chk_all(tag);
    endtask

    // Pull reset low between edges and check it acts without a clock.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_all(tag);
        #1;
        reset = 1'b1;
    endtask

    logic [7:0] pat;
    int         last_md;

    initial begin
        model_reset();
        // ---------------- reset state ----------------
        #12;
        chk_all("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- 1: shift right one word ----------------
        pat = 8'b0100_1101;   // d_in sequence 1,0,1,1,0,0,1,0 (LSB first)
        for (int i = 0; i < 8; i++) step("t1.shr", 1'b1, 1'b0, 2'b01, pat[i], '0);
        chk("t1.q_word", 32'(q), 32'h4D);
        chk("t1.wv_hi", 32'(word_valid), 32'd1);
        step("t1.hold", 1'b1, 1'b0, 2'b00, 1'b0, '0);
        chk("t1.wv_one_cycle", 32'(word_valid), 32'd0);

        // ---------------- 2: load then shift left ----------------
        step("t2.load", 1'b1, 1'b0, 2'b11, 1'b0, 8'hA5);
        step("t2.shl0", 1'b1, 1'b0, 2'b10, 1'b0, '0);
        chk("t2.sout0", 32'(s_out), 32'd1);
        step("t2.shl1", 1'b1, 1'b0, 2'b10, 1'b0, '0);
        chk("t2.sout1", 32'(s_out), 32'd0);
        step("t2.shl2", 1'b1, 1'b0, 2'b10, 1'b0, '0);
        chk("t2.sout2", 32'(s_out), 32'd1);
        chk("t2.q", 32'(q), 32'h28);
        chk("t2.cnt", 32'(bit_cnt), 32'd3);

        // ---------------- 3: direction change ----------------
        step("t3.clr", 1'b1, 1'b1, 2'b00, 1'b0, '0);
        for (int i = 0; i < 5; i++) step("t3.shr", 1'b1, 1'b0, 2'b01, 1'($urandom), '0);
        step("t3.shl1", 1'b1, 1'b0, 2'b10, 1'b1, '0);
        chk("t3.cnt_restart", 32'(bit_cnt), 32'd1);
        for (int i = 0; i < 7; i++) step("t3.shl", 1'b1, 1'b0, 2'b10, 1'($urandom), '0);
        chk("t3.wv_after_8th_left", 32'(word_valid), 32'd1);

        // ---------------- 4: enable low, clear ignores enable ----------------
        step("t4.load", 1'b1, 1'b0, 2'b11, 1'b0, 8'h3C);
        for (int i = 0; i < 10; i++) step("t4.en0", 1'b0, 1'b0, 2'b01, 1'b1, '0);
        chk("t4.q_held", 32'(q), 32'h3C);
        step("t4.clr_en0", 1'b0, 1'b1, 2'b01, 1'b1, '0);
        chk("t4.q_clr", 32'(q), 32'h0);

        // ---------------- 5: back-to-back words ----------------
        for (int i = 0; i < 16; i++) begin
            step("t5.shr", 1'b1, 1'b0, 2'b01, 1'($urandom), '0);
            chk("t5.cnt_seq", 32'(bit_cnt), 32'((i + 1) % 8));
        end

        // ---------------- 6: asynchronous reset mid-word ----------------
        for (int i = 0; i < 5; i++) step("t6.shl", 1'b1, 1'b0, 2'b10, 1'b1, '0);
        chk("t6.cnt5", 32'(bit_cnt), 32'd5);
        async_reset("t6.async");
        chk("t6.cnt_zero", 32'(bit_cnt), 32'd0);
        for (int i = 0; i < 7; i++) step("t6.shl_pre", 1'b1, 1'b0, 2'b10, 1'b1, '0);
        chk("t6.no_early_wv", 32'(word_valid), 32'd0);
        step("t6.shl_8th", 1'b1, 1'b0, 2'b10, 1'b1, '0);
        chk("t6.wv", 32'(word_valid), 32'd1);

        // ---------------- randomised traffic ----------------
        last_md = 1;
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] md;
            r = int'($urandom_range(0, 99));
            if (r < 70)      md = 2'(last_md);
            else if (r < 82) md = 2'b01;
            else if (r < 94) md = 2'b10;
            else if (r < 97) md = 2'b11;
            else             md = 2'b00;
            last_md = int'(md);
            step("rand", ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 59) == 0), md, 1'($urandom), 8'($urandom));
            if (i % 150 == 77) async_reset("rand.async");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
Parametrised universal shift register. It is the successor to the fixed 4-bit serial-in/parallel-out register.
- Adds configurable width, bidirectional shifting, parallel load, synchronous clear and clock enable.
- Adds a registered serial output and a bit counter with a word-complete strobe.
- Serves as the serial/parallel conversion stage in front of the team's serial link and UART datapaths.

Parameters:
WIDTH, 8, register width in bits (>= 1)
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  clock enable for hold/shift/load
clr  input  1  synchronous clear; works regardless of en
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
d_in  input  1  serial data in
p_in  input  WIDTH  parallel load data
q  output  WIDTH  parallel register contents
s_out  output  1  registered copy of the bit most recently shifted out
bit_cnt  output  CNT_W  consecutive same-direction shifts since last word boundary
word_valid  output  1  one-cycle strobe: WIDTH consecutive same-direction shifts completed

Behaviour:
- reset=0, asynchronous, takes effect immediately:
  - q=0, s_out=0, bit_cnt=0, word_valid=0, direction FSM=IDLE.
  - Any shift in progress is abandoned.
- Direction FSM states: IDLE, SHR, SHL. It records the direction of the last shift.
- Update priority on each rising clk edge: clr, then en=0, then mode.
- clr=1: q=0, s_out=0, bit_cnt=0, word_valid=0, FSM->IDLE.
- en=0 (clr=0): q, s_out, bit_cnt and FSM hold; word_valid=0.
- mode 00, hold: q, s_out, bit_cnt and FSM hold; word_valid=0.
- mode 11, parallel load: q=p_in; bit_cnt=0; FSM->IDLE; s_out holds; word_valid=0.
- mode 01, shift right: q <= {d_in, q[WIDTH-1:1]}; s_out <= old q[0]; FSM->SHR. d_in enters at the MSB, matching the previous block's ordering.
- mode 10, shift left: q <= {q[WIDTH-2:0], d_in}; s_out <= old q[WIDTH-1]; FSM->SHL.
- For WIDTH=1: any shift sets q <= d_in and s_out <= old q[0].
- Counting on a shift:
  - n = 1 if the FSM was IDLE or held the opposite direction; otherwise n = bit_cnt+1.
  - If n == WIDTH: bit_cnt <= 0 and word_valid <= 1.
  - Otherwise: bit_cnt <= n and word_valid <= 0.
- word_valid timing:
  - High for exactly one cycle after the completing edge, while q holds the complete word.
  - A shift in the same direction on the next edge starts the next word at count 1; there are no gap cycles.
- A direction change restarts counting at 1 with the current shift. Data already in q is kept, not cleared.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency:
  - Load, shift and clear are visible on q one edge later.
  - The first full word needs WIDTH shift edges after reset, clr, load or a direction change.

Test Plan:
1. Reset low, then release. Shift right with d_in = 1,0,1,1,0,0,1,0 on 8 consecutive edges -> q=0x4D after the 8th edge; word_valid high for exactly that one cycle; bit_cnt=0.
2. Load p_in=0xA5, then 3 shift-left edges with d_in=0 -> q=0x28; s_out sequence 1,0,1; bit_cnt=3; word_valid never asserted.
3. 5 shift-right edges, then 1 shift-left edge -> bit_cnt=1. Then 7 more shift-left edges -> word_valid pulses only after the 8th left shift.
4. Load 0x3C, hold en=0 with mode=01 for 10 edges -> q=0x3C and bit_cnt unchanged. Then clr=1 with en=0 -> q=0 and bit_cnt=0 after the next edge.
5. 16 back-to-back shift-right edges -> word_valid pulses after the 8th and 16th edges only; bit_cnt goes 1..7, 0, 1..7, 0.
6. Pull reset low between clock edges at bit_cnt=5 -> q=0 and bit_cnt=0 immediately. After release, 8 shifts are required before word_valid.
